proc_ctrl_fsm: RTL and testbench

Instruction sequencer for the 9-bit processor datapath. It fetches a 9-bit instruction word from the shared data input and steps through timesteps T0–T3. In each timestep it drives the select of the 10:1 bus multiplexer, the register write enables, the ALU operand/result latches and the add/sub control. The block holds the instruction register and the FSM; the register file, ALU and bus multiplexer live outside it.

---
 rtl/proc_ctrl_fsm.sv | 139 +++++++++++++
 tb/tb_proc_ctrl_fsm.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/proc_ctrl_fsm.sv
// Instruction sequencer for the 9-bit processor datapath.
// Holds the instruction register and the T0..T3 step FSM. It decodes the state
// and the IR into the bus-mux select and the datapath enables.
// Optional feature: define CTRL_MVNZ_EN to decode opcode 100 as mvnz
// (a conditional move on gNz). When the macro is not defined, opcode 100 is a NOP.
module proc_ctrl_fsm (
    input  logic       clk,
    input  logic       resetn,
    input  logic       run,
    input  logic [8:0] din,
    input  logic       gNz,
    output logic [3:0] ctrlVar,
    output logic [7:0] rIn,
    output logic       aIn,
    output logic       gIn,
    output logic       addSub,
    output logic       irIn,
    output logic       done
);

    typedef enum logic [1:0] {StT0, StT1, StT2, StT3} state_e;

    localparam logic [2:0] OpMv   = 3'b000;
    localparam logic [2:0] OpMvi  = 3'b001;
    localparam logic [2:0] OpAdd  = 3'b010;
    localparam logic [2:0] OpSub  = 3'b011;
`ifdef CTRL_MVNZ_EN
    localparam logic [2:0] OpMvnz = 3'b100;
`endif

    localparam logic [3:0] SelDin  = 4'd8;
    localparam logic [3:0] SelG    = 4'd9;
    localparam logic [3:0] SelIdle = 4'hF;

    state_e     state_q;
    logic [8:0] ir_q;

    logic [2:0] opcode;
    logic [2:0] x_sel;
    logic [2:0] y_sel;
    logic [7:0] x_onehot;

    assign opcode   = ir_q[8:6];
    assign x_sel    = ir_q[5:3];
    assign y_sel    = ir_q[2:0];
    assign x_onehot = 8'd1 << x_sel;

`ifndef CTRL_MVNZ_EN
    // gNz only matters for mvnz.
    logic unused_gnz;
    assign unused_gnz = gNz;
`endif

    // State register and instruction fetch; IR only loads in T0 with run high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StT0;
            ir_q    <= 9'd0;
        end else begin
            unique case (state_q)
                StT0: begin
                    if (run) begin
                        ir_q    <= din;
                        state_q <= StT1;
                    end
                end
                StT1: begin
                    if (opcode == OpAdd || opcode == OpSub) begin
                        state_q <= StT2;
                    end else begin
                        state_q <= StT0;
                    end
                end
                StT2:    state_q <= StT3;
                StT3:    state_q <= StT0;
                default: state_q <= StT0;
            endcase
        end
    end

    // Combinational decode of state and IR into the mux select and enables.
    always_comb begin
        ctrlVar = SelIdle;
        rIn     = 8'd0;
        aIn     = 1'b0;
        gIn     = 1'b0;
        addSub  = 1'b0;
        irIn    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StT0: begin
                irIn = run;
            end
            StT1: begin
                case (opcode)
                    OpMv: begin
                        ctrlVar = {1'b0, y_sel};
                        rIn     = x_onehot;
                        done    = 1'b1;
                    end
                    OpMvi: begin
                        ctrlVar = SelDin;
                        rIn     = x_onehot;
                        done    = 1'b1;
                    end
                    OpAdd, OpSub: begin
                        ctrlVar = {1'b0, x_sel};
                        aIn     = 1'b1;
                    end
`ifdef CTRL_MVNZ_EN
                    OpMvnz: begin
                        ctrlVar = {1'b0, y_sel};
                        rIn     = gNz ? x_onehot : 8'd0;
                        done    = 1'b1;
                    end
`endif
                    default: begin
                        done = 1'b1;
                    end
                endcase
            end
            // T2/T3 are only reachable for add/sub.
            StT2: begin
                ctrlVar = {1'b0, y_sel};
                gIn     = 1'b1;
                addSub  = (opcode == OpSub);
            end
            StT3: begin
                ctrlVar = SelG;
                rIn     = x_onehot;
                done    = 1'b1;
            end
            default: begin
                ctrlVar = SelIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Scoreboard bench for proc_ctrl_fsm. The stimulus pushes the expected output
// record for each non-idle cycle. The monitor pops a record and compares it
// whenever the DUT drives any output away from idle.
module tb_proc_ctrl_fsm;

    logic       clk;
    logic       resetn;
    logic       run;
    logic [8:0] din;
    logic       gNz;
    logic [3:0] ctrlVar;
    logic [7:0] rIn;
    logic       aIn;
    logic       gIn;
    logic       addSub;
    logic       irIn;
    logic       done;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];

    proc_ctrl_fsm dut (
        .clk     (clk),
        .resetn  (resetn),
        .run     (run),
        .din     (din),
        .gNz     (gNz),
        .ctrlVar (ctrlVar),
        .rIn     (rIn),
        .aIn     (aIn),
        .gIn     (gIn),
        .addSub  (addSub),
        .irIn    (irIn),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record layout: {ctrlVar, rIn, aIn, gIn, addSub, irIn, done}
    function automatic logic [16:0] rec(input logic [3:0] c, input logic [7:0] r,
                                        input logic a, input logic g, input logic s,
                                        input logic i, input logic d);
        return {c, r, a, g, s, i, d};
    endfunction

    // Drive one cycle of inputs; queue the expected record unless it is idle.
    task automatic step(input logic rn, input logic r, input logic [8:0] d,
                        input logic g, input logic [16:0] e);
        resetn = rn;
        run    = r;
        din    = d;
        gNz    = g;
        if (e != rec(4'hF, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [16:0] got;
        logic [16:0] exp;
        got = {ctrlVar, rIn, aIn, gIn, addSub, irIn, done};
        if (ctrlVar != 4'hF || rIn != 8'd0 || aIn || gIn || addSub || irIn || done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_output t=%0t: got ctrlVar=%h rIn=%b aIn=%b gIn=%b addSub=%b irIn=%b done=%b, required idle",
                         $time, ctrlVar, rIn, aIn, gIn, addSub, irIn, done);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL output_record t=%0t: got %h (ctrlVar=%h rIn=%b) required %h (ctrlVar=%h rIn=%b)",
                             $time, got, got[16:13], got[12:5], exp, exp[16:13], exp[12:5]);
                end
            end
        end
    end

    localparam logic [16:0] Idle  = 17'h1E000;
    localparam logic [16:0] Fetch = 17'h1E002;

    initial begin
        resetn = 1'b0;
        run    = 1'b0;
        din    = 9'd0;
        gNz    = 1'b0;
        @(posedge clk);
        #1;
        // Reset state, including irIn following run.
        step(1'b0, 1'b0, 9'd0, 1'b0, Idle);
        step(1'b0, 1'b1, 9'd0, 1'b0, rec(4'hF, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        step(1'b1, 1'b0, 9'd0, 1'b0, Idle);
        // mv R3,R5
        step(1'b1, 1'b1, 9'b000_011_101, 1'b0, Fetch);
        step(1'b1, 1'b0, 9'd0, 1'b0, rec(4'd5, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        step(1'b1, 1'b0, 9'd0, 1'b0, Idle);
        // mvi R2,#0x1A5
        step(1'b1, 1'b1, 9'b001_010_000, 1'b0, Fetch);
        step(1'b1, 1'b0, 9'h1A5, 1'b0, rec(4'd8, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        // add R0,R1
        step(1'b1, 1'b1, 9'b010_000_001, 1'b0, Fetch);
        step(1'b1, 1'b0, 9'd0, 1'b0, rec(4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b1, 1'b0, 9'd0, 1'b0, rec(4'd1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1'b1, 1'b0, 9'd0, 1'b0, rec(4'd9, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        // sub R7,R6: run toggles and din changes mid-instruction; the next fetch follows done
        step(1'b1, 1'b1, 9'b011_111_110, 1'b0, Fetch);
        step(1'b1, 1'b1, 9'h1FF, 1'b0, rec(4'd7, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b1, 1'b0, 9'h1FF, 1'b0, rec(4'd6, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        step(1'b1, 1'b1, 9'h1FF, 1'b0, rec(4'd9, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        step(1'b1, 1'b1, 9'b000_001_010, 1'b0, Fetch);
        step(1'b1, 1'b0, 9'd0, 1'b0, rec(4'd2, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        // add aborted by reset during T2: no further enables
        step(1'b1, 1'b1, 9'b010_000_001, 1'b0, Fetch);
        step(1'b1, 1'b0, 9'd0, 1'b0, rec(4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 9'd0, 1'b0, Idle);
        step(1'b0, 1'b0, 9'd0, 1'b0, Idle);
        step(1'b1, 1'b0, 9'd0, 1'b0, Idle);
        step(1'b1, 1'b0, 9'd0, 1'b0, Idle);
        // Opcode 100, X=4, Y=2 with gNz=1 then gNz=0
        step(1'b1, 1'b1, 9'b100_100_010, 1'b1, Fetch);
`ifdef CTRL_MVNZ_EN
        step(1'b1, 1'b0, 9'd0, 1'b1, rec(4'd2, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
`else
        step(1'b1, 1'b0, 9'd0, 1'b1, rec(4'hF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
`endif
        step(1'b1, 1'b1, 9'b100_100_010, 1'b0, Fetch);
`ifdef CTRL_MVNZ_EN
        step(1'b1, 1'b0, 9'd0, 1'b0, rec(4'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
`else
        step(1'b1, 1'b0, 9'd0, 1'b0, rec(4'hF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
`endif
        // Unused opcode 111 is a NOP
        step(1'b1, 1'b1, 9'h1FF, 1'b0, Fetch);
        step(1'b1, 1'b0, 9'd0, 1'b0, rec(4'hF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        repeat (4) step(1'b1, 1'b0, 9'd0, 1'b0, Idle);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: got %0d unconsumed records, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
